// File: rtl/seq_mult16_pkg.sv
// Shared types and constants for the iterative 16x16 multiplier.
// State encoding and iteration count live here.
package seq_mult16_pkg;

  localparam int WIDTH = 16;
  localparam int ITER  = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    NEG,
    DONE
  } state_t;

endpackage

// File: rtl/seq_mult16_mag16.sv
// Arithmetic leaf cells: ones complement, 16-bit ripple-carry adder,
// and the operand magnitude unit built from them.
module onesComp (
  input  logic [15:0] x,
  output logic [15:0] y
);

  assign y = ~x;

endmodule

module sixteenbitrca (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic [16:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < 16; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) |
                      (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[16];

endmodule

module mag16 (
  input  logic [15:0] value,
  input  logic        is_signed,
  output logic [15:0] mag
);

  logic [15:0] inv;
  logic [15:0] neg;
  logic        unused_cout;

  onesComp u_inv (
    .x (value),
    .y (inv)
  );

  // two's-complement negate: ~x + 1
  sixteenbitrca u_inc (
    .a    (inv),
    .b    (16'h0000),
    .cin  (1'b1),
    .sum  (neg),
    .cout (unused_cout)
  );

  assign mag = (is_signed & value[15]) ? neg : value;

endmodule

// File: rtl/seq_mult16.sv
// Radix-2 shift-and-add multiplier, one 16-bit add per cycle,
// with start/ready/done handshake and sign fix-up stage.
module seq_mult16 #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic               overflow
);

  import seq_mult16_pkg::*;

  state_t             state;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;
  logic [CNT_W-1:0]   cnt;
  logic               neg;
  logic               sgn;

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH-1:0]   acc_sum;
  logic               acc_c;

  logic [WIDTH-1:0]   hi_n;
  logic [WIDTH-1:0]   lo_n;
  logic [WIDTH-1:0]   p_hi;
  logic [WIDTH-1:0]   p_lo;
  logic               p_lo_c;
  logic               unused_cout;

  logic [2*WIDTH-1:0] prod_next;
  logic               ovf_next;

  mag16 u_mag_a (
    .value     (a),
    .is_signed (is_signed),
    .mag       (a_mag)
  );

  mag16 u_mag_b (
    .value     (b),
    .is_signed (is_signed),
    .mag       (b_mag)
  );

  assign addend = lo[0] ? mcand : '0;

  sixteenbitrca u_acc (
    .a    (hi),
    .b    (addend),
    .cin  (1'b0),
    .sum  (acc_sum),
    .cout (acc_c)
  );

  onesComp u_inv_lo (
    .x (lo),
    .y (lo_n)
  );

  onesComp u_inv_hi (
    .x (hi),
    .y (hi_n)
  );

  // 32-bit negate as two chained 16-bit adds
  sixteenbitrca u_neg_lo (
    .a    (lo_n),
    .b    ('0),
    .cin  (1'b1),
    .sum  (p_lo),
    .cout (p_lo_c)
  );

  sixteenbitrca u_neg_hi (
    .a    (hi_n),
    .b    ('0),
    .cin  (p_lo_c),
    .sum  (p_hi),
    .cout (unused_cout)
  );

  assign prod_next = neg ? {p_hi, p_lo} : {hi, lo};

  assign ovf_next = sgn
    ? (prod_next[2*WIDTH-1:WIDTH]
       != {WIDTH{prod_next[WIDTH-1]}})
    : (|prod_next[2*WIDTH-1:WIDTH]);

  assign busy = ~ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      mcand    <= '0;
      hi       <= '0;
      lo       <= '0;
      cnt      <= '0;
      neg      <= 1'b0;
      sgn      <= 1'b0;
      ready    <= 1'b1;
      done     <= 1'b0;
      product  <= '0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            mcand <= a_mag;
            lo    <= b_mag;
            hi    <= '0;
            cnt   <= '0;
            neg   <= is_signed &
                     (a[WIDTH-1] ^ b[WIDTH-1]);
            sgn   <= is_signed;
            ready <= 1'b0;
            state <= RUN;
          end
        end
        RUN: begin
          // 33-bit right shift of {carry, sum, lo}
          hi  <= {acc_c, acc_sum[WIDTH-1:1]};
          lo  <= {acc_sum[0], lo[WIDTH-1:1]};
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(ITER - 1))
            state <= NEG;
        end
        NEG: begin
          product  <= prod_next;
          overflow <= ovf_next;
          state    <= DONE;
        end
        DONE: begin
          done  <= 1'b1;
          ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult16.sv
// Self-checking bench for seq_mult16: directed vectors,
// randomized back-to-back operations, abort and ignore cases.
module tb_seq_mult16;

  logic        clk;
  logic        reset;
  logic        start;
  logic        is_signed;
  logic [15:0] a;
  logic [15:0] b;
  logic        ready;
  logic        busy;
  logic        done;
  logic [31:0] product;
  logic        overflow;

  int n_cmp;
  int n_bad;

  seq_mult16 dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .is_signed (is_signed),
    .a         (a),
    .b         (b),
    .ready     (ready),
    .busy      (busy),
    .done      (done),
    .product   (product),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  function automatic void model(
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic        s,
    output logic [31:0] p,
    output logic        ov
  );
    longint r;
    if (s)
      r = longint'($signed(x)) * longint'($signed(y));
    else
      r = longint'(x) * longint'(y);
    p  = r[31:0];
    ov = s ? (r < -32768 || r > 32767) : (r > 65535);
  endfunction

  // Starts an op now (caller sits just after an edge with ready=1),
  // runs 18 edges and checks the done cycle. poke>0 pulses a
  // stray start with 4x4 sampled at that edge.
  task automatic do_op(
    input logic [15:0] oa,
    input logic [15:0] ob,
    input logic        s,
    input int          poke,
    input string       name
  );
    logic [31:0] ep;
    logic        eov;
    bit          bad;
    model(oa, ob, s, ep, eov);
    a = oa;
    b = ob;
    is_signed = s;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    a = 16'($urandom);
    b = 16'($urandom);
    is_signed = 1'($urandom);
    bad = 0;
    for (int k = 1; k <= 18; k++) begin
      if (poke != 0 && k == poke) begin
        start = 1;
        a = 16'd4;
        b = 16'd4;
      end
      @(posedge clk); #1;
      if (poke != 0 && k == poke) start = 0;
      if (k < 18 && (done !== 1'b0 || ready !== 1'b0 ||
                     busy !== 1'b1))
        bad = 1;
    end
    n_cmp++;
    if (bad) begin
      n_bad++;
      $display("FAIL %s busy_phase: handshake wrong before cycle 18", name);
    end
    n_cmp++;
    if (done !== 1'b1) begin
      n_bad++;
      $display("FAIL %s done18: got %b want 1", name, done);
    end
    n_cmp++;
    if (product !== ep) begin
      n_bad++;
      $display("FAIL %s product: got %h want %h", name, product, ep);
    end
    n_cmp++;
    if (overflow !== eov) begin
      n_bad++;
      $display("FAIL %s overflow: got %b want %b", name, overflow, eov);
    end
    n_cmp++;
    if (ready !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s ready_after: got %b/%b want 1/0", name, ready, busy);
    end
  endtask

  task automatic test_reset();
    reset = 0;
    start = 0;
    is_signed = 0;
    a = 0;
    b = 0;
    #12;
    n_cmp++;
    if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_hs: got r%b b%b d%b want 1 0 0", ready, busy, done);
    end
    n_cmp++;
    if (product !== 32'h0 || overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_prod: got %h/%b want 0/0", product, overflow);
    end
    @(negedge clk);
    reset = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    do_op(16'd3, 16'd5, 1'b0, 0, "u3x5");
    do_op(16'hFFFF, 16'hFFFF, 1'b0, 0, "uffff");
    do_op(16'hFFFD, 16'h0007, 1'b1, 0, "s_m3x7");
    do_op(16'h8000, 16'h8000, 1'b1, 0, "s8000sq");
    do_op(16'h0000, 16'h8000, 1'b1, 0, "s0x8000");
    do_op(16'h0007, 16'hFFFF, 1'b1, 0, "s7xm1");
    do_op(16'h8000, 16'h0001, 1'b1, 0, "s8000x1");
  endtask

  task automatic test_ignore_start();
    do_op(16'd2, 16'd9, 1'b0, 5, "ignore");
    @(posedge clk); #1;
    n_cmp++;
    if (done !== 1'b0 || ready !== 1'b1) begin
      n_bad++;
      $display("FAIL ignore_single: got d%b r%b want 0 1", done, ready);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) begin
      logic [15:0] ra;
      logic [15:0] rb;
      logic        rs;
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = 1'($urandom);
      if (i % 8 == 3) ra = 16'h8000;
      if (i % 8 == 5) rb = 16'h0000;
      if (i % 8 == 6) rb = 16'hFFFF;
      do_op(ra, rb, rs, 0, "rand");
      if (i % 5 == 4)
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk); #1;
        end
    end
  endtask

  task automatic test_reset_abort();
    bit seen;
    a = 16'h1234;
    b = 16'h0010;
    is_signed = 0;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (8) @(posedge clk);
    #1;
    reset = 0;
    #1;
    n_cmp++;
    if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_hs: got r%b b%b d%b want 1 0 0", ready, busy, done);
    end
    n_cmp++;
    if (product !== 32'h0 || overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_prod: got %h/%b want 0/0", product, overflow);
    end
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done !== 1'b0) seen = 1;
    end
    @(negedge clk);
    reset = 1;
    repeat (12) begin
      @(posedge clk); #1;
      if (done !== 1'b0) seen = 1;
    end
    n_cmp++;
    if (seen) begin
      n_bad++;
      $display("FAIL abort_nodone: got done pulse want none");
    end
    do_op(16'd6, 16'd7, 1'b0, 0, "after_abort");
  endtask

  initial begin
    clk = 0;
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_directed();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
